// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a synchronized lock,
// qualifies it for a stable window, then reports ready; gives up after repeated timeouts.
module pll_lock_sequencer #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_reset,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    localparam int MAX_AB  = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RESET_CYCLES
                                                                      : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_ALL = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;
    localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    llc_q, llc_d;
    logic [1:0]    sync_q, sync_d;
    logic          locked_s;

    assign locked_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], pll_locked};
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        llc_d   = llc_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == CW'(PLL_RESET_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = (retry_d == RW'(MAX_RETRIES)) ? FAULT : PLL_RST;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                // A drop on the final qualifying cycle still disqualifies the lock.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = PLL_RST;
                    if (llc_q != 8'hff) llc_d = llc_q + 8'd1;
                end
            end
            FAULT: cnt_d = '0;
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PLL_RST;
            cnt_q   <= '0;
            retry_q <= '0;
            llc_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            llc_q   <= llc_d;
            sync_q  <= sync_d;
        end
    end

    assign pll_reset       = (state_q == PLL_RST) || (state_q == FAULT);
    assign ready           = (state_q == RUN);
    assign fault           = (state_q == FAULT);
    assign lock_loss_count = llc_q;
    assign state           = state_q;

endmodule
